// File: rtl/multicycle_control.sv
// Moore-style sequencer for the multi-cycle MIPS datapath.
// Drives mux selects and write enables per state, stalls on mem_ready, counts retired instructions.
module multicycle_control #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic                   pc_source,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_dst,
    output logic                   reg_write,
    output logic                   mem_to_reg,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [3:0]             alu_op,
    output logic                   illegal_instr,
    output logic [3:0]             state,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2b);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);

    localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_NOR  = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_SRA  = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_SLTU = ALU_W'(10);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        R_EXEC    = 4'd2,
        R_WB      = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_READ  = 4'd5,
        MEM_WB    = 4'd6,
        MEM_WRITE = 4'd7,
        BRANCH    = 4'd8,
        ILLEGAL   = 4'd9
    } state_t;

    state_t                 cur_state;
    state_t                 next_state;
    logic                   retire;
    logic                   r_valid;
    logic                   r_shamt;
    logic [ALU_W-1:0]       r_alu_op;

    // R-type funct decode: ALU code, legality, and whether A comes from shamt
    always_comb begin
        r_valid  = 1'b1;
        r_shamt  = 1'b0;
        r_alu_op = ALU_ADD;
        case (funct)
            6'h20, 6'h21: r_alu_op = ALU_ADD;
            6'h22, 6'h23: r_alu_op = ALU_SUB;
            6'h24:        r_alu_op = ALU_AND;
            6'h25:        r_alu_op = ALU_OR;
            6'h26:        r_alu_op = ALU_XOR;
            6'h27:        r_alu_op = ALU_NOR;
            6'h2a:        r_alu_op = ALU_SLT;
            6'h2b:        r_alu_op = ALU_SLTU;
            6'h00: begin r_alu_op = ALU_SLL; r_shamt = 1'b1; end
            6'h02: begin r_alu_op = ALU_SRL; r_shamt = 1'b1; end
            6'h03: begin r_alu_op = ALU_SRA; r_shamt = 1'b1; end
            6'h04:        r_alu_op = ALU_SLL;
            6'h06:        r_alu_op = ALU_SRL;
            6'h07:        r_alu_op = ALU_SRA;
            default:      r_valid  = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state   <= FETCH;
            instr_count <= '0;
        end else begin
            cur_state <= next_state;
            if (retire) begin
                instr_count <= instr_count + COUNT_WIDTH'(1);
            end
        end
    end

    // Next-state and Moore outputs; FETCH/MEM_* also look at mem_ready
    always_comb begin
        next_state    = FETCH;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        alu_op        = ALU_ADD;
        illegal_instr = 1'b0;

        case (cur_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = DECODE;
                end else begin
                    next_state = FETCH;
                end
            end
            DECODE: begin
                alu_src_b = 2'd3;
                if (opcode == OP_RTYPE && r_valid) begin
                    next_state = R_EXEC;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    next_state = MEM_ADDR;
                end else if (opcode == OP_BEQ) begin
                    next_state = BRANCH;
                end else begin
                    next_state = ILLEGAL;
                end
            end
            R_EXEC: begin
                alu_op     = r_alu_op;
                alu_src_a  = r_shamt ? 2'd2 : 2'd1;
                next_state = R_WB;
            end
            R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            MEM_ADDR: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                end else begin
                    next_state = MEM_WRITE;
                end
            end
            BRANCH: begin
                alu_src_a     = 2'd1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                retire        = 1'b1;
            end
            ILLEGAL: begin
                illegal_instr = 1'b1;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its states.
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, pc_source, i_or_d;
    logic        mem_read, mem_write, ir_write, reg_dst, reg_write, mem_to_reg;
    logic [1:0]  alu_src_a, alu_src_b;
    logic [3:0]  alu_op;
    logic        illegal_instr;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(.COUNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_instr(illegal_instr),
        .state(state), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20;
        tick();
        check("rst_state", 32'(state), 0);
        check("rst_count", instr_count, 0);
        check("rst_reg_write", 32'(reg_write), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_illegal", 32'(illegal_instr), 0);
        reset = 1'b0;
        #1;
        check("fetch_mem_read", 32'(mem_read), 1);
        check("fetch_ir_write", 32'(ir_write), 1);
        check("fetch_pc_write", 32'(pc_write), 1);
        check("fetch_src_b", 32'(alu_src_b), 1);

        // R-type add
        tick();
        check("add_s1", 32'(state), 1);
        check("dec_src_b", 32'(alu_src_b), 3);
        check("dec_ir_write", 32'(ir_write), 0);
        tick();
        check("add_s2", 32'(state), 2);
        check("add_alu_op", 32'(alu_op), 0);
        check("add_src_a", 32'(alu_src_a), 1);
        check("add_src_b", 32'(alu_src_b), 0);
        tick();
        check("add_s3", 32'(state), 3);
        check("add_reg_write", 32'(reg_write), 1);
        check("add_reg_dst", 32'(reg_dst), 1);
        check("add_count_pre", instr_count, 0);
        tick();
        check("add_s0", 32'(state), 0);
        check("add_count", instr_count, 1);

        // lw with two stall cycles in MEM_READ
        opcode = 6'h23;
        tick();
        tick();
        check("lw_s4", 32'(state), 4);
        check("lw_src_b", 32'(alu_src_b), 2);
        check("lw_src_a", 32'(alu_src_a), 1);
        tick();
        check("lw_s5", 32'(state), 5);
        mem_ready = 1'b0;
        #1;
        check("lw_mem_read", 32'(mem_read), 1);
        check("lw_i_or_d", 32'(i_or_d), 1);
        tick();
        check("lw_stall1", 32'(state), 5);
        check("lw_stall_read", 32'(mem_read), 1);
        check("lw_stall_rw", 32'(reg_write), 0);
        tick();
        check("lw_stall2", 32'(state), 5);
        mem_ready = 1'b1;
        tick();
        check("lw_s6", 32'(state), 6);
        check("lw_mem_to_reg", 32'(mem_to_reg), 1);
        check("lw_reg_dst", 32'(reg_dst), 0);
        check("lw_reg_write", 32'(reg_write), 1);
        tick();
        check("lw_s0", 32'(state), 0);
        check("lw_count", instr_count, 2);

        // sw then beq
        opcode = 6'h2b;
        tick();
        tick();
        tick();
        check("sw_s7", 32'(state), 7);
        check("sw_mem_write", 32'(mem_write), 1);
        check("sw_mem_read", 32'(mem_read), 0);
        tick();
        check("sw_s0", 32'(state), 0);
        check("sw_count", instr_count, 3);
        opcode = 6'h04;
        tick();
        tick();
        check("beq_s8", 32'(state), 8);
        check("beq_cond", 32'(pc_write_cond), 1);
        check("beq_src", 32'(pc_source), 1);
        check("beq_alu_op", 32'(alu_op), 1);
        check("beq_pc_write", 32'(pc_write), 0);
        tick();
        check("beq_s0", 32'(state), 0);
        check("beq_count", instr_count, 4);

        // sll uses shamt
        opcode = 6'h00; funct = 6'h00;
        tick();
        tick();
        check("sll_s2", 32'(state), 2);
        check("sll_alu_op", 32'(alu_op), 6);
        check("sll_src_a", 32'(alu_src_a), 2);
        tick();
        tick();
        check("sll_count", instr_count, 5);

        // illegal opcode
        opcode = 6'h08;
        tick();
        tick();
        check("ill_s9", 32'(state), 9);
        check("ill_pulse", 32'(illegal_instr), 1);
        check("ill_reg_write", 32'(reg_write), 0);
        tick();
        check("ill_s0", 32'(state), 0);
        check("ill_pulse_end", 32'(illegal_instr), 0);
        check("ill_count", instr_count, 5);

        // illegal funct
        opcode = 6'h00; funct = 6'h3f;
        tick();
        tick();
        check("illf_s9", 32'(state), 9);
        check("illf_pulse", 32'(illegal_instr), 1);
        tick();
        check("illf_count", instr_count, 5);

        // FETCH stall gates ir_write/pc_write but keeps mem_read
        mem_ready = 1'b0;
        #1;
        check("fstall_read", 32'(mem_read), 1);
        check("fstall_ir", 32'(ir_write), 0);
        check("fstall_pc", 32'(pc_write), 0);
        tick();
        check("fstall_state", 32'(state), 0);
        mem_ready = 1'b1;

        // reset during a MEM_READ stall
        opcode = 6'h23;
        tick();
        tick();
        tick();
        check("rst2_s5", 32'(state), 5);
        mem_ready = 1'b0;
        tick();
        check("rst2_stall", 32'(state), 5);
        reset = 1'b1;
        tick();
        check("rst2_state", 32'(state), 0);
        check("rst2_count", instr_count, 0);
        check("rst2_i_or_d", 32'(i_or_d), 0);
        reset = 1'b0;
        tick();
        check("rst2_hold_fetch", 32'(state), 0);
        check("rst2_fetch_read", 32'(mem_read), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
